// File: rtl/complex_dot_row_scheduler.sv
// Row scheduler for the complex dot-product unit: computes y = A*x one row per dot product.
// Each row clears the unit, streams PKGS operand packages, waits for the unit's sticky
// finish under timeout supervision, then writes the result.
module complex_dot_row_scheduler #(
  parameter int unsigned element_width = 64,
  parameter int unsigned NI            = 8,
  parameter int unsigned NOE           = 8,
  parameter int unsigned ROWS          = 8,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          mat_rd_en_o,
  output logic [ADDR_W-1:0]             mat_rd_addr_o,
  input  logic [element_width*NI-1:0]   mat_rd_data_i,
  output logic                          vec_rd_en_o,
  output logic [ADDR_W-1:0]             vec_rd_addr_o,
  input  logic [element_width*NI-1:0]   vec_rd_data_i,
  output logic                          dp_reset_o,
  output logic [element_width*NI-1:0]   dp_first_row_o,
  output logic [element_width*NI-1:0]   dp_second_row_o,
  output logic                          dp_read_now_o,
  input  logic                          dp_finish_i,
  input  logic [element_width-1:0]      dp_result_i,
  output logic                          res_wr_en_o,
  output logic [ADDR_W-1:0]             res_addr_o,
  output logic [element_width-1:0]      res_data_o
);

  localparam int unsigned PKGS      = NOE / NI + 1;
  localparam int unsigned DATA_PKGS = (NOE + NI - 1) / NI;
  localparam int unsigned PW        = element_width * NI;
  localparam int unsigned TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle, StClr, StFetch, StLatch, StIssue, StWait, StStore, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;
  logic                capture;

  logic                busy_q, done_q, dp_reset_q, read_now_q, res_wr_en_q, rd_en_q;
  logic                fetch_d;
  logic [ADDR_W-1:0]   mat_addr_q, vec_addr_q, res_addr_q, fetch_addr;
  logic [PW-1:0]       first_q, second_q;
  logic [element_width-1:0] res_data_q;

  // Next-state and control sequencing.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    timer_d = timer_q;
    err_d   = err_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          row_d   = '0;
          err_d   = 1'b0;
          state_d = StClr;
        end
      end
      StClr: begin
        k_d     = '0;
        state_d = StFetch;
      end
      StFetch: state_d = StLatch;
      StLatch: state_d = StIssue;
      StIssue: begin
        if (k_q < ADDR_W'(PKGS - 1)) begin
          k_d     = k_q + ADDR_W'(1);
          state_d = StFetch;
        end else begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (dp_finish_i) begin
          capture = 1'b1;
          state_d = StStore;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StStore: begin
        if (row_q < ADDR_W'(ROWS - 1)) begin
          row_d   = row_q + ADDR_W'(1);
          state_d = StClr;
        end else begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reads are only issued for packages that carry memory data; padding packages are zero.
  always_comb begin
    fetch_d    = (state_d == StFetch) && (k_d < ADDR_W'(DATA_PKGS));
    fetch_addr = row_d * ADDR_W'(DATA_PKGS) + k_d;
  end

  // State and counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      row_q   <= '0;
      k_q     <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Registered outputs, decoded from the next state so they line up with the state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dp_reset_q  <= 1'b1;
      read_now_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      res_wr_en_q <= 1'b0;
      mat_addr_q  <= '0;
      vec_addr_q  <= '0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      busy_q      <= (state_d != StIdle) && (state_d != StDone);
      done_q      <= (state_d == StDone);
      dp_reset_q  <= (state_d == StIdle) || (state_d == StClr);
      read_now_q  <= (state_d == StIssue);
      rd_en_q     <= fetch_d;
      res_wr_en_q <= capture;
      if (fetch_d) begin
        mat_addr_q <= fetch_addr;
        vec_addr_q <= k_d;
      end
      if (capture) begin
        res_addr_q <= row_q;
        res_data_q <= dp_result_i;
      end
    end
  end

  // Operand latch: read data is valid in LATCH, so operands change only on that edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      first_q  <= '0;
      second_q <= '0;
    end else if (state_q == StLatch) begin
      if (k_q < ADDR_W'(DATA_PKGS)) begin
        first_q  <= mat_rd_data_i;
        second_q <= vec_rd_data_i;
      end else begin
        first_q  <= '0;
        second_q <= '0;
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign mat_rd_en_o     = rd_en_q;
  assign vec_rd_en_o     = rd_en_q;
  assign mat_rd_addr_o   = mat_addr_q;
  assign vec_rd_addr_o   = vec_addr_q;
  assign dp_reset_o      = dp_reset_q;
  assign dp_first_row_o  = first_q;
  assign dp_second_row_o = second_q;
  assign dp_read_now_o   = read_now_q;
  assign res_wr_en_o     = res_wr_en_q;
  assign res_addr_o      = res_addr_q;
  assign res_data_o      = res_data_q;

endmodule

// File: tb/tb_complex_dot_row_scheduler.sv
// Bench for complex_dot_row_scheduler: memory and dot-product-unit models, directed runs.
module tb_complex_dot_row_scheduler;

  localparam int NI = 8;
  localparam int NOE = 8;
  localparam int ROWS = 2;
  localparam int TIMEOUT = 64;
  localparam int PKGS = NOE / NI + 1;
  localparam int PW = 64 * NI;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, err, mat_rd_en, vec_rd_en, dp_reset, dp_read_now, dp_finish, res_wr_en;
  logic [15:0] mat_rd_addr, vec_rd_addr, res_addr;
  logic [PW-1:0] mat_rd_data, vec_rd_data, dp_first_row, dp_second_row;
  logic [63:0] dp_result, res_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  complex_dot_row_scheduler #(
    .element_width(64), .NI(NI), .NOE(NOE), .ROWS(ROWS), .ADDR_W(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .mat_rd_en_o(mat_rd_en), .mat_rd_addr_o(mat_rd_addr), .mat_rd_data_i(mat_rd_data),
    .vec_rd_en_o(vec_rd_en), .vec_rd_addr_o(vec_rd_addr), .vec_rd_data_i(vec_rd_data),
    .dp_reset_o(dp_reset), .dp_first_row_o(dp_first_row), .dp_second_row_o(dp_second_row),
    .dp_read_now_o(dp_read_now), .dp_finish_i(dp_finish), .dp_result_i(dp_result),
    .res_wr_en_o(res_wr_en), .res_addr_o(res_addr), .res_data_o(res_data)
  );

  // Memories with one-cycle read latency.
  logic [PW-1:0] mat_mem [0:7];
  logic [PW-1:0] vec_mem [0:1];
  always @(posedge clk) begin
    if (mat_rd_en) mat_rd_data <= mat_mem[mat_rd_addr[2:0]];
    if (vec_rd_en) vec_rd_data <= vec_mem[vec_rd_addr[0]];
  end

  function automatic logic [PW-1:0] mk_pkg(input int re, input int im);
    logic [PW-1:0] p;
    for (int i = 0; i < NI; i++) p[i*64 +: 64] = {re[31:0], im[31:0]};
    return p;
  endfunction

  function automatic logic [63:0] cdot(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int sr, si, ar, ai, br, bi;
    sr = 0;
    si = 0;
    for (int i = 0; i < NI; i++) begin
      ar = $signed(a[i*64+32 +: 32]);
      ai = $signed(a[i*64 +: 32]);
      br = $signed(b[i*64+32 +: 32]);
      bi = $signed(b[i*64 +: 32]);
      sr = sr + ar * br - ai * bi;
      si = si + ar * bi + ai * br;
    end
    return {sr[31:0], si[31:0]};
  endfunction

  // Dot-product unit model: accumulates on each strobe, sticky finish after PKGS strobes.
  int acc_re = 0, acc_im = 0, pk_cnt = 0;
  logic fin = 1'b0;
  logic no_fin = 1'b0;
  logic force_fin = 1'b0;
  logic [63:0] prod;
  always @(posedge clk) begin
    prod = cdot(dp_first_row, dp_second_row);
    if (dp_reset) begin
      acc_re <= 0; acc_im <= 0; pk_cnt <= 0; fin <= 1'b0;
    end else begin
      if (dp_read_now) begin
        acc_re <= acc_re + $signed(prod[63:32]);
        acc_im <= acc_im + $signed(prod[31:0]);
        pk_cnt <= pk_cnt + 1;
      end
      if (pk_cnt == PKGS && !no_fin) fin <= 1'b1;
    end
  end
  assign dp_finish = fin | force_fin;
  assign dp_result = {acc_re[31:0], acc_im[31:0]};

  // Output monitor.
  logic clr_mon = 1'b0;
  int strobe_cnt, wr_cnt, done_cnt, done_cyc, zero_ok, op_viol, hold, rst_run, rst_max;
  int strobe_cyc [0:15];
  logic [15:0] wr_addr [0:7];
  logic [63:0] wr_data [0:7];
  logic [63:0] first_op0;
  logic [PW-1:0] hold_a, hold_b;
  always @(negedge clk) begin
    if (clr_mon) begin
      strobe_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = 0; zero_ok = 0;
      op_viol = 0; hold = 0; rst_run = 0; rst_max = 0; first_op0 = '0;
    end else begin
      if (dp_read_now) begin
        if (strobe_cnt < 16) strobe_cyc[strobe_cnt] = cyc;
        if (strobe_cnt == 0) first_op0 = dp_first_row[63:0];
        if (strobe_cnt % 2 == 1 && dp_first_row == '0 && dp_second_row == '0)
          zero_ok = zero_ok + 1;
        hold_a = dp_first_row;
        hold_b = dp_second_row;
        hold = 2;
        strobe_cnt = strobe_cnt + 1;
      end else if (hold > 0) begin
        if (dp_first_row != hold_a || dp_second_row != hold_b) op_viol = op_viol + 1;
        hold = hold - 1;
      end
      if (res_wr_en && wr_cnt < 8) begin
        wr_addr[wr_cnt] = res_addr;
        wr_data[wr_cnt] = res_data;
        wr_cnt = wr_cnt + 1;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (busy && dp_reset) rst_run = rst_run + 1;
      else rst_run = 0;
      if (rst_run > rst_max) rst_max = rst_run;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge clk);
    #1 clr_mon = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_val(tag, 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_strobes(input int target, input int bound);
    int s, n;
    s = 0;
    n = 0;
    while (s < target && n < bound) begin
      @(negedge clk);
      if (dp_read_now) s++;
      n++;
    end
    if (s < target) check_val("strobe_wait", 64'(s), 64'(target));
  endtask

  localparam logic [63:0] R11 = {32'd8, 32'd8};
  localparam logic [63:0] R20 = {32'd16, 32'd0};

  initial begin
    for (int i = 0; i < 8; i++) mat_mem[i] = mk_pkg(1, 1);
    vec_mem[0] = mk_pkg(1, 0);
    vec_mem[1] = mk_pkg(1, 0);
    repeat (3) @(negedge clk);

    // Reset state.
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_dp_reset", 64'(dp_reset), 64'd1);
    check_val("rst_rd_en", 64'({mat_rd_en, vec_rd_en, dp_read_now, res_wr_en}), 64'd0);
    check_val("rst_res_data", res_data, 64'd0);
    reset = 1'b0;
    clear_mon();

    // Two-row run with an ignored start pulse while in WAIT.
    pulse_start();
    check_val("busy_after_start", 64'(busy), 64'd1);
    wait_strobes(1, 50);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("run1_done", 200);
    repeat (5) @(negedge clk);
    check_val("run1_strobes", 64'(strobe_cnt), 64'd4);
    check_val("run1_zero_pkg", 64'(zero_ok), 64'd2);
    check_val("run1_first_op", first_op0, {32'd1, 32'd1});
    check_val("run1_space_r0", 64'(strobe_cyc[1] - strobe_cyc[0]), 64'd3);
    check_val("run1_space_r1", 64'(strobe_cyc[3] - strobe_cyc[2]), 64'd3);
    check_val("run1_op_stable", 64'(op_viol), 64'd0);
    check_val("run1_writes", 64'(wr_cnt), 64'd2);
    check_val("run1_addr0", 64'(wr_addr[0]), 64'd0);
    check_val("run1_data0", wr_data[0], R11);
    check_val("run1_addr1", 64'(wr_addr[1]), 64'd1);
    check_val("run1_data1", wr_data[1], R11);
    check_val("run1_done_cnt", 64'(done_cnt), 64'd1);
    check_val("run1_err", 64'(err), 64'd0);
    check_val("run1_idle", 64'(busy), 64'd0);
    check_val("run1_clr_len", 64'(rst_max), 64'd1);

    // Timeout: the unit never finishes.
    no_fin = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("to_done", 300);
    check_val("to_err", 64'(err), 64'd1);
    check_val("to_writes", 64'(wr_cnt), 64'd0);
    check_val("to_wait_len", 64'(done_cyc - strobe_cyc[1]), 64'(TIMEOUT + 1));
    check_val("to_done_cnt", 64'(done_cnt), 64'd1);
    no_fin = 1'b0;
    clear_mon();
    pulse_start();
    check_val("err_cleared", 64'(err), 64'd0);
    wait_done("rerun_done", 200);
    check_val("rerun_writes", 64'(wr_cnt), 64'd2);
    check_val("rerun_err", 64'(err), 64'd0);

    // Async reset during the second row's FETCH.
    clear_mon();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!(mat_rd_en && mat_rd_addr == 16'd1) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_val("row1_fetch_seen", 64'(mat_rd_en && mat_rd_addr == 16'd1), 64'd1);
    end
    #1 reset = 1'b1;
    #1;
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_dp_reset", 64'(dp_reset), 64'd1);
    check_val("arst_rd_en", 64'({mat_rd_en, vec_rd_en}), 64'd0);
    check_val("arst_addr", 64'(mat_rd_addr), 64'd0);
    check_val("arst_res_data", res_data, 64'd0);
    check_val("arst_operand", dp_first_row[63:0], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    pulse_start();
    wait_done("post_rst_done", 200);
    check_val("post_rst_addr0", 64'(wr_addr[0]), 64'd0);
    check_val("post_rst_data0", wr_data[0], R11);

    // Stale finish held high across the row boundary must not be captured early.
    mat_mem[1] = mk_pkg(2, 0);
    clear_mon();
    pulse_start();
    force_fin = 1'b1;
    wait_strobes(3, 100);
    force_fin = 1'b0;
    wait_done("stale_done", 200);
    check_val("stale_writes", 64'(wr_cnt), 64'd2);
    check_val("stale_data0", wr_data[0], R11);
    check_val("stale_addr1", 64'(wr_addr[1]), 64'd1);
    check_val("stale_data1", wr_data[1], R20);
    check_val("stale_clr_len", 64'(rst_max), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/complex_dot_row_scheduler.md
Name: complex_dot_row_scheduler

Overview:
Sequences the complex dot-product unit to compute a complex matrix-vector product y = A*x, one row per dot product. It fetches NI-element operand packages from matrix and vector read ports and clears the unit between rows. It pulses the unit's read-now strobe, waits for its sticky finish, and writes each result to a result port. Timeout supervision aborts the run if the unit never finishes.

Parameters:
element_width, 64, bits per complex element (real/imag halves packed as in the dot-product unit)
NI, 8, elements per package (even; unit multiplies NI/2 per cycle)
NOE, 8, elements per row / vector length
ROWS, 8, matrix rows per run
PKGS, NOE/NI+1, packages issued per row (integer division; matches the unit's padded package count)
DATA_PKGS, (NOE+NI-1)/NI, packages that carry memory data; packages k>=DATA_PKGS are all-zero
ADDR_W, 16, read/result address width
TIMEOUT, 64, max cycles in WAIT before abort

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  begin run; sampled only in IDLE
busy  out  1  high from accept of start until done
done  out  1  one-cycle pulse at end of run (normal or abort)
err  out  1  sticky timeout flag; cleared on accepted start
mat_rd_en  out  1  matrix read strobe
mat_rd_addr  out  ADDR_W  row*DATA_PKGS+k
mat_rd_data  in  element_width*NI  valid exactly 1 cycle after mat_rd_en
vec_rd_en  out  1  vector read strobe (same cycle as mat_rd_en)
vec_rd_addr  out  ADDR_W  k
vec_rd_data  in  element_width*NI  valid 1 cycle after vec_rd_en
dp_reset  out  1  synchronous reset to dot-product unit
dp_first_row  out  element_width*NI  registered matrix package
dp_second_row  out  element_width*NI  registered vector package
dp_read_now  out  1  one-cycle package strobe
dp_finish  in  1  unit finish (sticky until dp_reset)
dp_result  in  element_width  unit dot-product output
res_wr_en  out  1  one-cycle result write
res_addr  out  ADDR_W  row index
res_data  out  element_width  captured dp_result

Behaviour:
- Reset (async, any state): state=IDLE, row=0, k=0, timer=0. busy, done, err, mat/vec_rd_en, dp_read_now, res_wr_en = 0. Addresses, operands, res_data = 0. dp_reset=1.
- dp_reset=1 in IDLE and CLR, 0 in all other states (registered).
- IDLE: start -> row=0, err=0, busy=1 -> CLR.
- CLR (1 cycle): holds the unit cleared, k=0 -> FETCH.
- FETCH (1 cycle): if k<DATA_PKGS, assert rd_en on both ports with addresses row*DATA_PKGS+k and k; otherwise no read. -> LATCH.
- LATCH (1 cycle): dp_first_row/dp_second_row <= read data (or all-zero if k>=DATA_PKGS). -> ISSUE.
- ISSUE (1 cycle): dp_read_now=1. k<PKGS-1 -> k++, FETCH; else timer=0 -> WAIT.
- Operands change only at the LATCH edge, so they are stable for >=3 cycles after each strobe, covering the unit's two half-loads. Strobe period is 3 cycles.
- WAIT: dp_finish=1 -> res_data<=dp_result, res_addr<=row, res_wr_en=1 next cycle -> STORE. Otherwise timer++. timer==TIMEOUT-1 without finish -> err=1 -> DONE.
- STORE (1 cycle): row<ROWS-1 -> row++, CLR; else DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- start outside IDLE is ignored. dp_finish outside WAIT is ignored (stale sticky finish is cleared by CLR).
- Latency per row = 1 (CLR) + 3*PKGS + W + 1, where W = cycles in WAIT including the finish cycle.

Test Plan:
- NOE=8, NI=8, ROWS=2; A rows all (1+1j), x all (1+0j); pulse start. Required: 2 strobes per row, the second with zero operands. Results (8+8j) written at res_addr 0 then 1. done pulses once. err=0.
- Strobe spacing: check dp_read_now pulses exactly 3 cycles apart, and that operands do not change for 3 cycles following each pulse.
- Model holds dp_finish=0; TIMEOUT=64. Required: err=1 and done after exactly 64 WAIT cycles. No res_wr_en. Next start clears err.
- Assert reset during the second row's FETCH. Required: same-cycle async return to IDLE, all outputs at reset values, dp_reset=1. A new start computes row 0 correctly.
- Pulse start while busy in WAIT. Required: ignored; exactly ROWS writes and one done.
- dp_finish left high from the prior row before CLR. Required: not captured; the row's result is taken only after new strobes, with dp_reset=1 visible for 1 cycle between rows.
